ts_ddr_writer: RTL

Capture-side DDR write stage for the MPEG-TS recorder. Accepts an unstallable 8-bit transport-stream byte stream, aligns it to 188-byte packets, packs bytes into 32-bit words, buffers them in a small FIFO and drains them to the 64 MB DDR3 write port as sequential word writes in a circular region. It sits between the TS input front end and the DDR write interface, and its output region is what the playback/read logic consumes.

---
 rtl/ts_ddr_writer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ts_ddr_writer.sv
// ts_ddr_writer: MPEG-TS capture stage.
// - Aligns the incoming byte stream to 188-byte packets.
// - Packs the bytes into little-endian 32-bit words.
// - Buffers the words in a small FIFO.
// - Writes them sequentially into a circular DDR word region.
// Optional feature: define TS_WRITER_SYNC_CHECK_EN to require the 8'h47 sync
// byte on ts_sop before a packet is accepted.
module ts_ddr_writer #(
    parameter logic [23:0] ADDR_BASE  = 24'h000000,
    parameter logic [23:0] ADDR_WORDS = 24'h100000,
    parameter int          FIFO_AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ts_data,
    input  logic        ts_valid,
    input  logic        ts_sop,
    output logic [23:0] ddr_write_address,
    input  logic        ddr_write_waitrequest,
    output logic        ddr_write_write,
    output logic [31:0] ddr_write_writedata,
    output logic [3:0]  ddr_write_byteenable,
    output logic [23:0] words_written,
    output logic        overflow,
    output logic        sync_error,
    output logic        wrapped
);
    localparam int              DEPTH     = 1 << FIFO_AW;
    localparam logic [23:0]     ADDR_LAST = ADDR_BASE + ADDR_WORDS - 24'd1;
    localparam logic [7:0]      LAST_BYTE = 8'd187;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {HUNT, CAPTURE, DROP} pk_state_e;
    typedef enum logic       {IDLE, WRITE}         wr_state_e;

    pk_state_e          pk_state_q, pk_state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [23:0]        part_q, part_d;
    wr_state_e          wr_state_q, wr_state_d;
    logic [23:0]        addr_q, addr_d;
    logic [23:0]        words_q, words_d;
    logic               ovf_q, ovf_d;
    logic               sync_q, sync_d;
    logic               wrap_q, wrap_d;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               fifo_full, fifo_empty;
    logic               word_done, push, pop;
    logic [31:0]        word_data;
    logic               sync_ok, start;

`ifdef TS_WRITER_SYNC_CHECK_EN
    assign sync_ok = (ts_data == 8'h47);
`else
    assign sync_ok = 1'b1;
`endif

    assign start      = ts_valid & ts_sop & enable & sync_ok;
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign pop        = (wr_state_q == WRITE) & ~ddr_write_waitrequest;
    // A completed word enters the FIFO if there is room, or if the head leaves this cycle.
    assign push       = word_done & (~fifo_full | pop);

    // Packer: packet alignment, byte-lane packing and framing/overflow flags.
    always_comb begin
        pk_state_d = pk_state_q;
        cnt_d      = cnt_q;
        part_d     = part_q;
        sync_d     = sync_q;
        ovf_d      = ovf_q;
        word_done  = 1'b0;
        word_data  = {ts_data, part_q};
        if (ts_valid) begin
            if (pk_state_q == CAPTURE && !ts_sop) begin
                cnt_d = cnt_q + 8'd1;
                case (cnt_q[1:0])
                    2'd0:    part_d[7:0]   = ts_data;
                    2'd1:    part_d[15:8]  = ts_data;
                    2'd2:    part_d[23:16] = ts_data;
                    default: word_done     = 1'b1;
                endcase
                if (cnt_q == LAST_BYTE) begin
                    pk_state_d = HUNT;
                    cnt_d      = '0;
                end
                if (word_done && fifo_full && !pop) begin
                    ovf_d      = 1'b1;
                    pk_state_d = DROP;
                    cnt_d      = '0;
                end
            end else if (ts_sop) begin
                // A sop inside a packet truncates it; the byte is then judged as a fresh start.
                if (pk_state_q == CAPTURE) sync_d = 1'b1;
`ifdef TS_WRITER_SYNC_CHECK_EN
                if (enable && !sync_ok) sync_d = 1'b1;
`endif
                pk_state_d = HUNT;
                cnt_d      = '0;
                if (start) begin
                    pk_state_d  = CAPTURE;
                    cnt_d       = 8'd1;
                    part_d[7:0] = ts_data;
                end
            end
        end
    end

    // Writer: present the FIFO head to DDR and advance the circular address on accept.
    always_comb begin
        wr_state_d = wr_state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        wrap_d     = wrap_q;
        case (wr_state_q)
            IDLE: begin
                if (!fifo_empty) wr_state_d = WRITE;
            end
            WRITE: begin
                if (pop) begin
                    words_d = words_q + 24'd1;
                    if (addr_q == ADDR_LAST) begin
                        addr_d = ADDR_BASE;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 24'd1;
                    end
                    if (count_q == CNT_ONE && !push) wr_state_d = IDLE;
                end
            end
            default: wr_state_d = IDLE;
        endcase
    end

    // State, counters and sticky flags.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pk_state_q <= HUNT;
            cnt_q      <= '0;
            part_q     <= '0;
            wr_state_q <= IDLE;
            addr_q     <= ADDR_BASE;
            words_q    <= '0;
            ovf_q      <= 1'b0;
            sync_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            pk_state_q <= pk_state_d;
            cnt_q      <= cnt_d;
            part_q     <= part_d;
            wr_state_q <= wr_state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            sync_q     <= sync_d;
            wrap_q     <= wrap_d;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: the memory has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= word_data;
    end

    assign ddr_write_write      = (wr_state_q == WRITE);
    assign ddr_write_writedata  = ddr_write_write ? mem[rd_ptr_q] : 32'h0;
    assign ddr_write_address    = addr_q;
    assign ddr_write_byteenable = 4'hF;
    assign words_written        = words_q;
    assign overflow             = ovf_q;
    assign sync_error           = sync_q;
    assign wrapped              = wrap_q;
endmodule
